instr_fetch_queue: RTL and testbench



---
 rtl/instr_fetch_queue.sv | 126 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one word request at a time and
// buffers {pc, instruction} pairs for decode. `define FETCH_PERF_EN adds the pop counter.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_pc;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [XLEN-1:0]   inst_mem [DEPTH];

  logic              has_room;
  logic              req_fire;
  logic              push;
  logic              pop;

  // Handshake qualifiers; reset and redirect suppress visibility in the same cycle
  assign has_room      = (count < CNT_W'(DEPTH));
  assign mem_req_valid = ~rst & (state == REQ) & has_room;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid & mem_req_ready;
  assign inst_valid    = ~rst & (count != '0) & ~redirect_valid;
  assign pop           = inst_valid & inst_ready;
  assign push          = ~rst & ~redirect_valid & (state == WAIT) & mem_rsp_valid;
  assign inst_data     = inst_mem[rd_ptr];
  assign inst_pc       = pc_mem[rd_ptr];

  // Fetch control and queue bookkeeping; redirect outranks all traffic except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      unique case (state)
        REQ:         state <= req_fire ? DRAIN : REQ;
        WAIT, DRAIN: state <= mem_rsp_valid ? REQ : DRAIN;
        default:     state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= WAIT;
          end
        end
        WAIT, DRAIN: begin
          if (mem_rsp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; entries are only visible once counted
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= mem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_count_q;

  // Counts instructions handed to decode; redirect does not clear it
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + XLEN'(1);
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: memory model plus an in-order PC stream reference.
module tb_instr_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus knobs
  int unsigned ready_pct, iready_pct, redir_pct, rst_pm, lat_min, lat_max;
  logic        force_rst, force_redir;
  logic [31:0] force_tgt;

  // memory model: one response per accepted request after a random latency
  logic        mem_busy;
  int          mem_lat;
  logic [31:0] mem_addr;

  // reference: delivered PCs form a +4 stream restarted by reset or redirect
  logic [31:0] exp_pc, exp_req, exp_fc;
  logic        prev_stall;
  logic [31:0] prev_addr;

  // per-cycle observations for the scenario tasks
  logic        obs_rqv, obs_hs, obs_iv, obs_pop, obs_rsp;
  logic [31:0] obs_addr, obs_pc, obs_data, obs_fc;

  function automatic logic [31:0] perf_expect(input logic [31:0] n);
`ifdef FETCH_PERF_EN
    return n;
`else
    return 32'd0 & n;
`endif
  endfunction

  task automatic run_cycle();
    logic        redir, hs, pop, rsp;
    logic [31:0] tgt, rnd, addr_s;
    rst           = force_rst || ($urandom_range(0, 999) < rst_pm);
    mem_rsp_valid = !rst && mem_busy && (mem_lat == 0);
    mem_rsp_data  = mem_rsp_valid ? (mem_addr ^ KEY) : $urandom;
    mem_req_ready = ($urandom_range(0, 99) < ready_pct);
    inst_ready    = ($urandom_range(0, 99) < iready_pct);
    rnd = $urandom;
    if (force_redir) tgt = force_tgt;
    else if (rnd[2:0] == 3'd0) tgt = 32'hFFFF_FFF0 | {28'd0, rnd[7:4]};
    else tgt = $urandom;
    redir = force_redir || ($urandom_range(0, 99) < redir_pct);
    redirect_valid = redir;
    redirect_pc    = tgt;
    #1;
    checks++;
    if (rst) begin
      if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_outputs: req_valid=%b inst_valid=%b expected 0 0", mem_req_valid, inst_valid);
      end
    end else begin
      if (redir) begin
        if (inst_valid !== 1'b0) begin
          failures++;
          $display("FAIL redirect_hides_head: inst_valid=%b expected 0", inst_valid);
        end
      end else if (inst_valid === 1'b1) begin
        if (inst_pc !== exp_pc || inst_data !== (exp_pc ^ KEY)) begin
          failures++;
          $display("FAIL head_entry: pc=%h data=%h expected pc=%h data=%h",
                   inst_pc, inst_data, exp_pc, exp_pc ^ KEY);
        end
      end
      checks++;
      if (prev_stall && (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr)) begin
        failures++;
        $display("FAIL req_stable: valid=%b addr=%h expected 1 %h", mem_req_valid, mem_req_addr, prev_addr);
      end
      if (mem_req_valid === 1'b1) begin
        checks++;
        if (mem_req_addr !== exp_req || mem_busy) begin
          failures++;
          $display("FAIL req_addr: addr=%h busy=%b expected %h 0", mem_req_addr, mem_busy, exp_req);
        end
      end
      checks++;
      if (fetch_count !== perf_expect(exp_fc)) begin
        failures++;
        $display("FAIL fetch_count: got %0d expected %0d", fetch_count, perf_expect(exp_fc));
      end
    end
    obs_rqv  = mem_req_valid;
    obs_addr = mem_req_addr;
    obs_iv   = inst_valid;
    obs_pc   = inst_pc;
    obs_data = inst_data;
    obs_fc   = fetch_count;
    obs_rsp  = mem_rsp_valid;
    hs  = (mem_req_valid === 1'b1) && mem_req_ready;
    pop = (inst_valid === 1'b1) && inst_ready;
    rsp = mem_rsp_valid;
    addr_s = mem_req_addr;
    obs_hs  = hs;
    obs_pop = pop;
    @(posedge clk);
    if (rst) begin
      exp_pc = RESET_PC; exp_req = RESET_PC; exp_fc = 32'd0;
      mem_busy = 1'b0; mem_lat = 0; prev_stall = 1'b0;
    end else begin
      if (rsp) mem_busy = 1'b0;
      else if (mem_busy && mem_lat > 0) mem_lat--;
      if (hs) begin
        mem_busy = 1'b1;
        mem_addr = addr_s;
        mem_lat  = int'($urandom_range(lat_max, lat_min)) - 1;
      end
      if (pop) begin
        exp_pc = exp_pc + 32'd4;
        exp_fc = exp_fc + 32'd1;
      end
      if (redir) begin
        exp_pc  = tgt & ~32'd3;
        exp_req = tgt & ~32'd3;
      end else if (hs) begin
        exp_req = exp_req + 32'd4;
      end
      prev_stall = obs_rqv && !mem_req_ready && !redir;
      prev_addr  = addr_s;
    end
    @(negedge clk);
  endtask

  task automatic set_knobs(input int unsigned rdy, input int unsigned irdy, input int unsigned lat);
    ready_pct = rdy; iready_pct = irdy; lat_min = lat; lat_max = lat;
    redir_pct = 0; rst_pm = 0; force_redir = 1'b0; force_rst = 1'b0;
  endtask

  task automatic apply_reset();
    force_rst = 1'b1;
    run_cycle();
    run_cycle();
    force_rst = 1'b0;
  endtask

  task automatic test_reset();
    set_knobs(0, 0, 1);
    apply_reset();
    run_cycle();
    checks++;
    if (obs_rqv !== 1'b1 || obs_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_first_req: valid=%b addr=%h expected 1 %h", obs_rqv, obs_addr, RESET_PC);
    end
    checks++;
    if (obs_iv !== 1'b0 || obs_fc !== 32'd0) begin
      failures++;
      $display("FAIL reset_queue: inst_valid=%b fetch_count=%0d expected 0 0", obs_iv, obs_fc);
    end
  endtask

  task automatic test_latency();
    int first_iv;
    int pops;
    logic [31:0] pcs [4];
    set_knobs(100, 100, 1);
    apply_reset();
    first_iv = -1;
    pops = 0;
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      if (obs_iv && first_iv < 0) first_iv = c;
      if (obs_pop) begin
        if (pops < 4) pcs[pops] = obs_pc;
        if (pops == 0) begin
          checks++;
          if (obs_data !== 32'hA5A5_0000) begin
            failures++;
            $display("FAIL first_data: got %h expected a5a50000", obs_data);
          end
        end
        pops++;
      end
    end
    checks++;
    if (first_iv != 2) begin
      failures++;
      $display("FAIL first_valid_cycle: got %0d expected 2", first_iv);
    end
    checks++;
    if (pops != 9) begin
      failures++;
      $display("FAIL throughput: pops=%0d expected 9", pops);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pcs[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL pc_order_%0d: got %h expected %h", i, pcs[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    int hs_n;
    logic found;
    set_knobs(100, 0, 1);
    apply_reset();
    hs_n = 0;
    for (int c = 0; c < 20; c++) begin
      run_cycle();
      if (obs_hs) hs_n++;
    end
    checks++;
    if (hs_n != 4 || obs_rqv !== 1'b0) begin
      failures++;
      $display("FAIL full_stop: requests=%0d req_valid=%b expected 4 0", hs_n, obs_rqv);
    end
    iready_pct = 100;
    run_cycle();
    iready_pct = 0;
    checks++;
    if (obs_pop !== 1'b1) begin
      failures++;
      $display("FAIL single_pop: pop=%b expected 1", obs_pop);
    end
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      run_cycle();
      found = obs_hs;
    end
    checks++;
    if (!found || obs_addr !== 32'h10) begin
      failures++;
      $display("FAIL refill_req: seen=%b addr=%h expected 1 00000010", found, obs_addr);
    end
  endtask

  task automatic test_req_stall();
    logic found;
    set_knobs(0, 100, 1);
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      checks++;
      if (obs_rqv !== 1'b1 || obs_addr !== 32'h0) begin
        failures++;
        $display("FAIL stall_hold: valid=%b addr=%h expected 1 00000000", obs_rqv, obs_addr);
      end
    end
    ready_pct = 100;
    run_cycle();
    checks++;
    if (obs_hs !== 1'b1 || obs_addr !== 32'h0) begin
      failures++;
      $display("FAIL stall_accept: hs=%b addr=%h expected 1 00000000", obs_hs, obs_addr);
    end
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      run_cycle();
      found = obs_hs;
    end
    checks++;
    if (!found || obs_addr !== 32'h4) begin
      failures++;
      $display("FAIL stall_next: seen=%b addr=%h expected 1 00000004", found, obs_addr);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    set_knobs(100, 0, 3);
    apply_reset();
    for (int c = 0; c < 5; c++) run_cycle();
    force_redir = 1'b1;
    force_tgt   = 32'h103;
    run_cycle();
    force_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    run_cycle();
    checks++;
    if (obs_iv !== 1'b0 || obs_rqv !== 1'b0) begin
      failures++;
      $display("FAIL wait_flush: inst_valid=%b req_valid=%b expected 0 0", obs_iv, obs_rqv);
    end
    iready_pct = 100;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      run_cycle();
      found = obs_hs;
    end
    checks++;
    if (!found || obs_addr !== 32'h100) begin
      failures++;
      $display("FAIL wait_refetch: seen=%b addr=%h expected 1 00000100", found, obs_addr);
    end
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      run_cycle();
      found = obs_pop;
    end
    checks++;
    if (!found || obs_pc !== 32'h100) begin
      failures++;
      $display("FAIL wait_first_pc: seen=%b pc=%h expected 1 00000100", found, obs_pc);
    end
  endtask

  task automatic test_redirect_handshake();
    logic found;
    set_knobs(100, 100, 1);
    apply_reset();
    force_redir = 1'b1;
    force_tgt   = 32'h200;
    run_cycle();
    force_redir = 1'b0;
    checks++;
    if (obs_hs !== 1'b1) begin
      failures++;
      $display("FAIL orphan_hs: hs=%b expected 1", obs_hs);
    end
    run_cycle();
    checks++;
    if (obs_rqv !== 1'b0 || obs_rsp !== 1'b1) begin
      failures++;
      $display("FAIL orphan_drain: req_valid=%b rsp=%b expected 0 1", obs_rqv, obs_rsp);
    end
    run_cycle();
    checks++;
    if (obs_hs !== 1'b1 || obs_addr !== 32'h200) begin
      failures++;
      $display("FAIL orphan_refetch: hs=%b addr=%h expected 1 00000200", obs_hs, obs_addr);
    end
    force_redir = 1'b1;
    force_tgt   = 32'h300;
    run_cycle();
    force_redir = 1'b0;
    checks++;
    if (obs_rsp !== 1'b1 || obs_pop !== 1'b0) begin
      failures++;
      $display("FAIL rsp_redirect: rsp=%b pop=%b expected 1 0", obs_rsp, obs_pop);
    end
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      run_cycle();
      found = obs_pop;
    end
    checks++;
    if (!found || obs_pc !== 32'h300 || obs_data !== (32'h300 ^ KEY)) begin
      failures++;
      $display("FAIL rsp_redirect_pc: seen=%b pc=%h data=%h expected 1 00000300 %h",
               found, obs_pc, obs_data, 32'h300 ^ KEY);
    end
  endtask

  task automatic test_perf();
    int pops;
    set_knobs(100, 100, 1);
    apply_reset();
    pops = 0;
    for (int c = 0; c < 100 && pops < 7; c++) begin
      run_cycle();
      if (obs_pop) pops++;
    end
    iready_pct  = 0;
    force_redir = 1'b1;
    force_tgt   = 32'h40;
    run_cycle();
    force_redir = 1'b0;
    iready_pct  = 100;
    for (int c = 0; c < 100 && pops < 9; c++) begin
      run_cycle();
      if (obs_pop) pops++;
    end
    iready_pct = 0;
    run_cycle();
    checks++;
    if (pops != 9 || obs_fc !== perf_expect(32'd9)) begin
      failures++;
      $display("FAIL perf_count: pops=%0d count=%0d expected 9 %0d", pops, obs_fc, perf_expect(32'd9));
    end
    apply_reset();
    run_cycle();
    checks++;
    if (obs_fc !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: count=%0d expected 0", obs_fc);
    end
  endtask

  task automatic test_random();
    int pops;
    set_knobs(70, 60, 1);
    lat_max   = 4;
    redir_pct = 5;
    rst_pm    = 3;
    apply_reset();
    pops = 0;
    for (int c = 0; c < 4000; c++) begin
      run_cycle();
      if (obs_pop) pops++;
    end
    checks++;
    if (pops < 100) begin
      failures++;
      $display("FAIL random_progress: pops=%0d expected at least 100", pops);
    end
    set_knobs(100, 100, 1);
  endtask

  initial begin
    rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    mem_busy = 1'b0; mem_lat = 0; mem_addr = 32'd0; prev_stall = 1'b0; prev_addr = 32'd0;
    exp_pc = RESET_PC; exp_req = RESET_PC; exp_fc = 32'd0; force_tgt = 32'd0;
    set_knobs(0, 0, 1);
    @(negedge clk);
    test_reset();
    test_latency();
    test_backpressure();
    test_req_stall();
    test_redirect_wait();
    test_redirect_handshake();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
